instr_mem: RTL and testbench
============================

INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter RESET_INSTR, default 16'h0000, the word loaded into every memory entry on reset (JMP 0).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port pc  input  5  fetch address from the program counter.
REQ-005 SHALL have port fetch_en  input  1  fetch request, sampled each rising edge.
REQ-006 SHALL have port wr_valid  input  1  host write request.
REQ-007 SHALL have port wr_ready  output  1  write can be accepted this cycle.
REQ-008 SHALL have port wr_addr  input  5  host write address.
REQ-009 SHALL have port wr_data  input  16  host write word.
REQ-010 SHALL have port exec_valid  input  1  forced-instruction request.
REQ-011 SHALL have port exec_instr  input  16  forced instruction word.
REQ-012 SHALL have port exec_ready  output  1  forced instruction can be accepted this cycle.
REQ-013 SHALL have port instruction  output  16  registered instruction to the state machine.
REQ-014 SHALL have port instr_valid  output  1  instruction was updated by the last edge.
REQ-015 SHALL have port instr_forced  output  1  current instruction came from the exec path.

Function
REQ-016 SHALL hold 32 x 16-bit entries in flops, addressed 0..31; no wrap logic needed (5-bit addresses).
REQ-017 SHALL drive wr_ready high whenever rst_n is high; write completes on the edge where wr_valid and wr_ready are both high: mem[wr_addr] <= wr_data.
REQ-018 SHALL, on an edge with fetch_en high and no forced word selected, load instruction <= mem[pc], instr_forced <= 0, instr_valid <= 1; latency one cycle from pc to instruction.
REQ-019 SHALL, on an edge with fetch_en low, hold instruction and instr_forced, and set instr_valid <= 0.
REQ-020 SHALL, on the same edge as a fetch with wr_addr == pc and a write accepted, return wr_data (write-through bypass); memory also updated.
REQ-021 SHALL keep a one-entry exec buffer with a pending flag; exec_ready = !pending (combinational).
REQ-022 SHALL, on an edge with exec_valid and exec_ready high and fetch_en low, capture exec_instr and set pending.
REQ-023 SHALL, on an edge with exec_valid and exec_ready high and fetch_en high, load instruction <= exec_instr, instr_forced <= 1, instr_valid <= 1, and leave pending clear (bypass).
REQ-024 SHALL, on an edge with pending set and fetch_en high, load instruction <= buffered word, instr_forced <= 1, instr_valid <= 1, and clear pending; the pc fetch is dropped that edge.
REQ-025 SHALL give forced words priority over memory at every fetch; memory writes are unaffected by exec activity.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force all entries to RESET_INSTR, instruction to RESET_INSTR, instr_valid to 0, instr_forced to 0, pending to 0, wr_ready to 0, exec_ready to 0.
REQ-027 SHALL discard any pending forced word and any in-flight write when rst_n falls mid-operation; first fetch after release returns RESET_INSTR unless written.

Configuration
REQ-028 SHALL compile the exec path only when macro PIO_FORCE_EXEC_EN is defined; behaviour then per REQ-021..REQ-025.
REQ-029 SHALL, without PIO_FORCE_EXEC_EN, tie exec_ready and instr_forced to 0, ignore exec_valid/exec_instr, and fetch only from memory.

Verification
REQ-030 SHALL cover: reset, fetch_en=1, pc=7 -> instruction=16'h0000, instr_valid=1 next cycle.
REQ-031 SHALL cover: write addr 3 data 16'hE025, then fetch pc=3 -> instruction=16'hE025, instr_forced=0.
REQ-032 SHALL cover: write addr 5 data 16'h0009 and fetch pc=5 same edge -> instruction=16'h0009.
REQ-033 SHALL cover: exec_valid with 16'hE041 while fetch_en=0 -> exec_ready=0 next cycle; next fetch pc=3 -> instruction=16'hE041, instr_forced=1, exec_ready=1 after.
REQ-034 SHALL cover: pending exec word, rst_n pulsed low -> pending cleared, memory back to 16'h0000, exec_ready=1 after release.
REQ-035 SHALL cover: build without PIO_FORCE_EXEC_EN, exec_valid=1 with fetch pc=3 -> instruction=mem[3], instr_forced=0, exec_ready=0.

Source files
------------

// File: rtl/instr_mem.sv
// Instruction memory: 32 x 16-bit flop array with host write port and registered fetch.
// Define PIO_FORCE_EXEC_EN to build the forced-instruction (exec) path with its one-entry buffer.
module instr_mem #(
    parameter logic [15:0] RESET_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  pc,
    input  logic        fetch_en,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        exec_valid,
    input  logic [15:0] exec_instr,
    output logic        exec_ready,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic        instr_forced
);

    logic [15:0] mem_q [32];
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        wr_acc;
    logic [15:0] mem_word;

    assign wr_ready = rst_n;
    assign wr_acc   = wr_valid && wr_ready;

    // A write landing on the fetched address this edge is returned directly.
    assign mem_word = (wr_acc && (wr_addr == pc)) ? wr_data : mem_q[pc];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= RESET_INSTR;
            end
        end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef PIO_FORCE_EXEC_EN
    logic        pend_q, pend_d;
    logic        forced_q, forced_d;
    logic [15:0] buf_q, buf_d;
    logic        exec_acc;

    assign exec_ready   = rst_n && !pend_q;
    assign exec_acc     = exec_valid && exec_ready;
    assign instr_forced = forced_q;

    always_comb begin
        instr_d  = instr_q;
        forced_d = forced_q;
        valid_d  = fetch_en;
        pend_d   = pend_q;
        buf_d    = buf_q;
        if (fetch_en) begin
            if (pend_q) begin
                instr_d  = buf_q;
                forced_d = 1'b1;
                pend_d   = 1'b0;
            end else if (exec_acc) begin
                instr_d  = exec_instr;
                forced_d = 1'b1;
            end else begin
                instr_d  = mem_word;
                forced_d = 1'b0;
            end
        end else if (exec_acc) begin
            buf_d  = exec_instr;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            forced_q <= forced_d;
        end
    end

    // Buffer contents are only meaningful while pend_q is set, so no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
`else
    logic unused_exec;

    assign unused_exec  = ^{exec_valid, exec_instr};
    assign exec_ready   = 1'b0;
    assign instr_forced = 1'b0;

    always_comb begin
        instr_d = instr_q;
        valid_d = fetch_en;
        if (fetch_en) begin
            instr_d = mem_word;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= RESET_INSTR;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed scenarios plus randomized traffic
// compared against an array/queue reference model; works with or without PIO_FORCE_EXEC_EN.
module tb_instr_mem;

    logic        clk;
    logic        rst_n;
    logic [4:0]  pc;
    logic        fetch_en;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        exec_valid;
    logic [15:0] exec_instr;
    logic        exec_ready;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_forced;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_mem [32];
    logic [15:0] m_instr;
    logic        m_valid;
    logic        m_forced;
    logic [15:0] m_q [$];

`ifdef PIO_FORCE_EXEC_EN
    localparam bit FORCE_BUILD = 1'b1;
`else
    localparam bit FORCE_BUILD = 1'b0;
`endif

    instr_mem #(.RESET_INSTR(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .fetch_en     (fetch_en),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .exec_valid   (exec_valid),
        .exec_instr   (exec_instr),
        .exec_ready   (exec_ready),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_forced (instr_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_exec_ready();
        return FORCE_BUILD && rst_n && (m_q.size() == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
        m_instr  = 16'h0000;
        m_valid  = 1'b0;
        m_forced = 1'b0;
        m_q.delete();
    endtask

    task automatic idle_inputs();
        fetch_en   = 1'b0;
        wr_valid   = 1'b0;
        exec_valid = 1'b0;
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        bit ex_acc;
        ex_acc = exec_valid && model_exec_ready();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (wr_valid) m_mem[wr_addr] = wr_data;
            if (fetch_en) begin
                m_valid = 1'b1;
                if (m_q.size() != 0) begin
                    m_instr  = m_q.pop_front();
                    m_forced = 1'b1;
                end else if (ex_acc) begin
                    m_instr  = exec_instr;
                    m_forced = 1'b1;
                end else begin
                    m_instr  = m_mem[pc];
                    m_forced = 1'b0;
                end
            end else begin
                m_valid = 1'b0;
                if (ex_acc) m_q.push_back(exec_instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        pc = 5'd0; wr_addr = 5'd0; wr_data = 16'h0; exec_instr = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({instruction, instr_valid, instr_forced, wr_ready, exec_ready} !== {16'h0000, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got instr=%h v=%b f=%b wr_rdy=%b ex_rdy=%b, expected 0000 0 0 0 0",
                     instruction, instr_valid, instr_forced, wr_ready, exec_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || exec_ready !== FORCE_BUILD) begin
            errors++;
            $display("FAIL ready_after_release: got wr_rdy=%b ex_rdy=%b, expected 1 %b",
                     wr_ready, exec_ready, FORCE_BUILD);
        end
    endtask

    task automatic test_fetch_basic();
        fetch_en = 1'b1; pc = 5'd7;
        tick();
        checks++;
        if (instruction !== 16'h0000 || instr_valid !== 1'b1 || instr_forced !== 1'b0) begin
            errors++;
            $display("FAIL fetch_reset_word: got %h v=%b f=%b, expected 0000 1 0",
                     instruction, instr_valid, instr_forced);
        end
        fetch_en = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 16'h0000) begin
            errors++;
            $display("FAIL fetch_hold: got %h v=%b, expected 0000 0", instruction, instr_valid);
        end
    endtask

    task automatic test_write_fetch();
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 16'hE025;
        tick();
        wr_valid = 1'b0;
        fetch_en = 1'b1; pc = 5'd3;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (instruction !== 16'hE025 || instr_forced !== 1'b0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL write_then_fetch: got %h f=%b v=%b, expected e025 0 1",
                     instruction, instr_forced, instr_valid);
        end
    endtask

    task automatic test_write_bypass();
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 16'h0009;
        fetch_en = 1'b1; pc = 5'd5;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (instruction !== 16'h0009) begin
            errors++;
            $display("FAIL write_bypass: got %h, expected 0009", instruction);
        end
        tick();
        fetch_en = 1'b0;
        checks++;
        if (instruction !== 16'h0009) begin
            errors++;
            $display("FAIL bypass_mem_updated: got %h, expected 0009", instruction);
        end
    endtask

    task automatic test_exec_buffered();
        logic [15:0] exp_word;
        exp_word = FORCE_BUILD ? 16'hE041 : 16'hE025;
        exec_valid = 1'b1; exec_instr = 16'hE041; fetch_en = 1'b0;
        tick();
        exec_valid = 1'b0;
        checks++;
        if (exec_ready !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL exec_capture: got ex_rdy=%b v=%b, expected 0 0", exec_ready, instr_valid);
        end
        fetch_en = 1'b1; pc = 5'd3;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (instruction !== exp_word || instr_forced !== FORCE_BUILD || exec_ready !== FORCE_BUILD) begin
            errors++;
            $display("FAIL exec_release: got %h f=%b ex_rdy=%b, expected %h %b %b",
                     instruction, instr_forced, exec_ready, exp_word, FORCE_BUILD, FORCE_BUILD);
        end
    endtask

    task automatic test_exec_same_edge();
        logic [15:0] exp_word;
        exp_word = FORCE_BUILD ? 16'hE077 : 16'hE025;
        exec_valid = 1'b1; exec_instr = 16'hE077; fetch_en = 1'b1; pc = 5'd3;
        tick();
        exec_valid = 1'b0; fetch_en = 1'b0;
        checks++;
        if (instruction !== exp_word || instr_forced !== FORCE_BUILD || exec_ready !== FORCE_BUILD) begin
            errors++;
            $display("FAIL exec_same_edge: got %h f=%b ex_rdy=%b, expected %h %b %b",
                     instruction, instr_forced, exec_ready, exp_word, FORCE_BUILD, FORCE_BUILD);
        end
    endtask

    task automatic test_reset_mid();
        exec_valid = 1'b1; exec_instr = 16'hBEEF; fetch_en = 1'b0;
        tick();
        exec_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if ({instruction, instr_valid, instr_forced, wr_ready, exec_ready} !== {16'h0000, 4'b0000}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h v=%b f=%b wr_rdy=%b ex_rdy=%b, expected 0000 0 0 0 0",
                     instruction, instr_valid, instr_forced, wr_ready, exec_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (exec_ready !== FORCE_BUILD) begin
            errors++;
            $display("FAIL exec_ready_after_reset: got %b, expected %b", exec_ready, FORCE_BUILD);
        end
        fetch_en = 1'b1; pc = 5'd3;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (instruction !== 16'h0000 || instr_forced !== 1'b0) begin
            errors++;
            $display("FAIL mem_cleared_by_reset: got %h f=%b, expected 0000 0", instruction, instr_forced);
        end
    endtask

    task automatic test_random();
        logic [19:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            pc         = 5'($urandom);
            fetch_en   = ($urandom_range(0, 3) != 0);
            wr_valid   = ($urandom_range(0, 1) == 1);
            wr_addr    = ($urandom_range(0, 1) == 1) ? pc : 5'($urandom);
            wr_data    = 16'($urandom);
            exec_valid = ($urandom_range(0, 9) < 3);
            exec_instr = 16'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                rst_n = 1'b1;
                #1;
            end
            tick();
            got = {instruction, instr_valid, instr_forced, exec_ready, wr_ready};
            exp = {m_instr, m_valid, m_forced, model_exec_ready(), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cycle_%0d: got instr/v/f/exrdy/wrrdy=%h, expected %h", n, got, exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_write_fetch();
        test_write_bypass();
        test_exec_buffered();
        test_exec_same_edge();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
